// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for a single shared add/subtract unit.
// Operations run IDLE -> EXEC -> RESP; the result is held on RSP_* until the consumer accepts it.

module addsub_unit #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH:0] i_a,
    input  logic [WIDTH:0] i_b,
    input  logic           i_sub,
    output logic [WIDTH:0] o_r,
    output logic           o_cout,
    output logic           o_ovf
);
    logic [WIDTH:0]   w_bsel;
    logic [WIDTH+1:0] w_sum;

    // Subtract is A + ~B + 1, so the carry-out reads as "no borrow".
    assign w_bsel = i_sub ? ~i_b : i_b;
    assign w_sum  = {1'b0, i_a} + {1'b0, w_bsel} + {{(WIDTH+1){1'b0}}, i_sub};
    assign o_r    = w_sum[WIDTH:0];
    assign o_cout = w_sum[WIDTH+1];
    assign o_ovf  = (i_a[WIDTH] == w_bsel[WIDTH]) && (w_sum[WIDTH] != i_a[WIDTH]);
endmodule

module addsub_arbiter #(
    parameter int WIDTH = 3
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           VALID0,
    output logic           READY0,
    input  logic [WIDTH:0] A0,
    input  logic [WIDTH:0] B0,
    input  logic           SUB0,
    input  logic           VALID1,
    output logic           READY1,
    input  logic [WIDTH:0] A1,
    input  logic [WIDTH:0] B1,
    input  logic           SUB1,
    output logic           RSP_VALID,
    input  logic           RSP_READY,
    output logic           RSP_ID,
    output logic [WIDTH:0] RSP_RESULT,
    output logic           RSP_COUT,
    output logic           RSP_OVF,
    output logic [7:0]     OP_COUNT
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic           r_last;
    logic [WIDTH:0] r_a;
    logic [WIDTH:0] r_b;
    logic           r_sub;
    logic           r_id;

    logic           r_rsp_valid;
    logic           r_rsp_id;
    logic [WIDTH:0] r_rsp_result;
    logic           r_rsp_cout;
    logic           r_rsp_ovf;
    logic [7:0]     r_op_count;

    logic           w_grant0;
    logic           w_grant1;
    logic           w_hs;
    logic [WIDTH:0] w_r;
    logic           w_cout;
    logic           w_ovf;

    // Grants are gated by reset so nothing looks granted while reset is held.
    assign w_grant0 = RST_N && (r_state == IDLE) && VALID0 && (!VALID1 || r_last);
    assign w_grant1 = RST_N && (r_state == IDLE) && VALID1 && (!VALID0 || !r_last);
    assign w_hs     = w_grant0 || w_grant1;

    assign READY0     = w_grant0;
    assign READY1     = w_grant1;
    assign RSP_VALID  = r_rsp_valid;
    assign RSP_ID     = r_rsp_id;
    assign RSP_RESULT = r_rsp_result;
    assign RSP_COUT   = r_rsp_cout;
    assign RSP_OVF    = r_rsp_ovf;
    assign OP_COUNT   = r_op_count;

    addsub_unit #(.WIDTH(WIDTH)) u_alu (
        .i_a    (r_a),
        .i_b    (r_b),
        .i_sub  (r_sub),
        .o_r    (w_r),
        .o_cout (w_cout),
        .o_ovf  (w_ovf)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (RSP_READY) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state      <= IDLE;
            r_last       <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_sub        <= 1'b0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_cout   <= 1'b0;
            r_rsp_ovf    <= 1'b0;
            r_op_count   <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_hs) begin
                r_id  <= w_grant1;
                r_a   <= w_grant1 ? A1   : A0;
                r_b   <= w_grant1 ? B1   : B0;
                r_sub <= w_grant1 ? SUB1 : SUB0;
            end
            if (r_state == EXEC) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_id     <= r_id;
                r_rsp_result <= w_r;
                r_rsp_cout   <= w_cout;
                r_rsp_ovf    <= w_ovf;
                r_last       <= r_id;
            end
            if ((r_state == RESP) && RSP_READY) begin
                r_rsp_valid <= 1'b0;
                r_op_count  <= r_op_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed scenarios plus randomized
// traffic checked against an arithmetic reference model.
module tb_addsub_arbiter;
    localparam int WIDTH = 3;

    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic           VALID0 = 1'b0, VALID1 = 1'b0;
    logic           READY0, READY1;
    logic [WIDTH:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
    logic           SUB0 = 1'b0, SUB1 = 1'b0;
    logic           RSP_VALID, RSP_READY = 1'b0;
    logic           RSP_ID, RSP_COUT, RSP_OVF;
    logic [WIDTH:0] RSP_RESULT;
    logic [7:0]     OP_COUNT;

    int n_cmp = 0;
    int n_err = 0;
    bit m_last = 1'b1;
    int m_count = 0;

    addsub_arbiter #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .VALID0(VALID0), .READY0(READY0), .A0(A0), .B0(B0), .SUB0(SUB0),
        .VALID1(VALID1), .READY1(READY1), .A1(A1), .B1(B1), .SUB1(SUB1),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
        .RSP_RESULT(RSP_RESULT), .RSP_COUT(RSP_COUT), .RSP_OVF(RSP_OVF),
        .OP_COUNT(OP_COUNT)
    );

    always #5 CLK = ~CLK;

    // Reference: plain modular and signed arithmetic on 4-bit values.
    function automatic void ref_op(input logic [3:0] a, input logic [3:0] b, input logic sub,
                                   output logic [3:0] r, output logic c, output logic o);
        int ua, ub, sa, sb, s, t;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        s  = sub ? sa - sb : sa + sb;
        o  = (s < -8) || (s > 7);
        t  = (sub ? ua - ub : ua + ub) & 15;
        r  = t[3:0];
        c  = sub ? (ua >= ub) : (ua + ub > 15);
    endfunction

    task automatic test_reset;
        RST_N = 1'b0; VALID0 = 1'b1; VALID1 = 1'b1; RSP_READY = 1'b0;
        A0 = 4'd3; B0 = 4'd4; A1 = 4'd5; B1 = 4'd6;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_cmp++; if ({READY0, READY1} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", {READY0, READY1}); end
        n_cmp++; if (RSP_VALID !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", RSP_VALID); end
        n_cmp++; if (RSP_RESULT !== 4'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", RSP_RESULT); end
        n_cmp++; if (OP_COUNT !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", OP_COUNT); end
        n_cmp++; if ({RSP_ID, RSP_COUT, RSP_OVF} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {RSP_ID, RSP_COUT, RSP_OVF}); end
        RST_N = 1'b1; VALID0 = 1'b0; VALID1 = 1'b0;
        m_last = 1'b1; m_count = 0;
    endtask

    task automatic test_single_sub;
        @(negedge CLK);
        VALID0 = 1'b1; A0 = 4'd5; B0 = 4'd3; SUB0 = 1'b1; RSP_READY = 1'b1;
        #1;
        n_cmp++; if (READY0 !== 1'b1) begin n_err++; $display("FAIL sub_ready0: got %b want 1", READY0); end
        @(posedge CLK); @(negedge CLK);
        VALID0 = 1'b0; A0 = 4'd9;
        n_cmp++; if (RSP_VALID !== 1'b0) begin n_err++; $display("FAIL sub_exec_valid: got %b want 0", RSP_VALID); end
        @(posedge CLK); @(negedge CLK);
        n_cmp++; if (RSP_VALID !== 1'b1) begin n_err++; $display("FAIL sub_rsp_valid: got %b want 1", RSP_VALID); end
        n_cmp++; if ({RSP_ID, RSP_RESULT, RSP_COUT, RSP_OVF} !== {1'b0, 4'd2, 1'b1, 1'b0})
            begin n_err++; $display("FAIL sub_rsp: got id=%b r=%h c=%b o=%b want id=0 r=2 c=1 o=0", RSP_ID, RSP_RESULT, RSP_COUT, RSP_OVF); end
        @(posedge CLK); @(negedge CLK);
        m_count++; m_last = 1'b0;
        n_cmp++; if (RSP_VALID !== 1'b0) begin n_err++; $display("FAIL sub_rsp_drop: got %b want 0", RSP_VALID); end
        n_cmp++; if (OP_COUNT !== 8'(m_count)) begin n_err++; $display("FAIL sub_count: got %0d want %0d", OP_COUNT, m_count); end
    endtask

    task automatic test_tie_ovf;
        @(negedge CLK); RST_N = 1'b0;
        @(negedge CLK); RST_N = 1'b1;
        m_last = 1'b1; m_count = 0;
        VALID0 = 1'b1; A0 = 4'd0; B0 = 4'd1; SUB0 = 1'b1;
        VALID1 = 1'b1; A1 = 4'd7; B1 = 4'd1; SUB1 = 1'b0;
        RSP_READY = 1'b1;
        #1;
        n_cmp++; if ({READY0, READY1} !== 2'b10) begin n_err++; $display("FAIL tie_first_grant: got %b want 10", {READY0, READY1}); end
        @(posedge CLK); @(negedge CLK);
        n_cmp++; if ({READY0, READY1} !== 2'b00) begin n_err++; $display("FAIL tie_exec_ready: got %b want 00", {READY0, READY1}); end
        @(posedge CLK); @(negedge CLK);
        n_cmp++; if ({RSP_VALID, RSP_ID, RSP_RESULT, RSP_COUT, RSP_OVF} !== {1'b1, 1'b0, 4'hF, 1'b0, 1'b0})
            begin n_err++; $display("FAIL tie_rsp0: got v=%b id=%b r=%h c=%b o=%b want v=1 id=0 r=f c=0 o=0", RSP_VALID, RSP_ID, RSP_RESULT, RSP_COUT, RSP_OVF); end
        @(posedge CLK); @(negedge CLK);
        n_cmp++; if ({READY0, READY1} !== 2'b01) begin n_err++; $display("FAIL tie_second_grant: got %b want 01", {READY0, READY1}); end
        @(posedge CLK); @(posedge CLK); @(negedge CLK);
        n_cmp++; if ({RSP_VALID, RSP_ID, RSP_RESULT, RSP_COUT, RSP_OVF} !== {1'b1, 1'b1, 4'h8, 1'b0, 1'b1})
            begin n_err++; $display("FAIL tie_rsp1: got v=%b id=%b r=%h c=%b o=%b want v=1 id=1 r=8 c=0 o=1", RSP_VALID, RSP_ID, RSP_RESULT, RSP_COUT, RSP_OVF); end
        @(posedge CLK); @(negedge CLK);
        n_cmp++; if ({READY0, READY1} !== 2'b10) begin n_err++; $display("FAIL tie_third_grant: got %b want 10", {READY0, READY1}); end
        n_cmp++; if (OP_COUNT !== 8'd2) begin n_err++; $display("FAIL tie_count: got %0d want 2", OP_COUNT); end
        VALID0 = 1'b0; VALID1 = 1'b0;
        m_count = 2; m_last = 1'b1;
    endtask

    task automatic test_backpressure;
        logic [3:0] er; logic ec, eo;
        logic [6:0] snap;
        logic [7:0] cnt0;
        @(negedge CLK);
        RSP_READY = 1'b0;
        VALID1 = 1'b1; A1 = 4'($urandom); B1 = 4'($urandom); SUB1 = 1'($urandom);
        ref_op(A1, B1, SUB1, er, ec, eo);
        cnt0 = 8'(m_count);
        #1;
        n_cmp++; if (READY1 !== 1'b1) begin n_err++; $display("FAIL bp_grant: got %b want 1", READY1); end
        @(posedge CLK); @(negedge CLK);
        VALID1 = 1'b0; A1 = ~A1; B1 = ~B1;
        @(posedge CLK); @(negedge CLK);
        n_cmp++; if ({RSP_VALID, RSP_ID, RSP_RESULT, RSP_COUT, RSP_OVF} !== {1'b1, 1'b1, er, ec, eo})
            begin n_err++; $display("FAIL bp_rsp: got v=%b id=%b r=%h c=%b o=%b want v=1 id=1 r=%h c=%b o=%b", RSP_VALID, RSP_ID, RSP_RESULT, RSP_COUT, RSP_OVF, er, ec, eo); end
        snap = {RSP_ID, RSP_RESULT, RSP_COUT, RSP_OVF};
        VALID0 = 1'b1; VALID1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); @(negedge CLK);
            n_cmp++; if ({RSP_VALID, RSP_ID, RSP_RESULT, RSP_COUT, RSP_OVF} !== {1'b1, 1'b1, er, ec, eo})
                begin n_err++; $display("FAIL bp_hold[%0d]: got v=%b bits=%b want v=1 bits=%b", i, RSP_VALID, {RSP_ID, RSP_RESULT, RSP_COUT, RSP_OVF}, {1'b1, er, ec, eo}); end
            n_cmp++; if ({READY0, READY1} !== 2'b00) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 00", i, {READY0, READY1}); end
            n_cmp++; if (OP_COUNT !== cnt0) begin n_err++; $display("FAIL bp_count[%0d]: got %0d want %0d", i, OP_COUNT, cnt0); end
        end
        VALID0 = 1'b0; VALID1 = 1'b0; RSP_READY = 1'b1;
        @(posedge CLK); @(negedge CLK);
        m_count++; m_last = 1'b1;
        n_cmp++; if (RSP_VALID !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b want 0", RSP_VALID); end
        n_cmp++; if (OP_COUNT !== 8'(m_count)) begin n_err++; $display("FAIL bp_count_inc: got %0d want %0d", OP_COUNT, m_count); end
        n_cmp++; if ({RSP_ID, RSP_RESULT, RSP_COUT, RSP_OVF} !== snap) begin n_err++; $display("FAIL bp_after_hold: got %b want %b", {RSP_ID, RSP_RESULT, RSP_COUT, RSP_OVF}, snap); end
        VALID0 = 1'b1;
        #1;
        n_cmp++; if (READY0 !== 1'b1) begin n_err++; $display("FAIL bp_idle_again: got %b want 1", READY0); end
        VALID0 = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic bad;
        @(negedge CLK);
        VALID0 = 1'b1; A0 = 4'($urandom); B0 = 4'($urandom); SUB0 = 1'($urandom); RSP_READY = 1'b1;
        @(posedge CLK); @(negedge CLK);
        VALID0 = 1'b0; RST_N = 1'b0;
        @(posedge CLK); @(negedge CLK);
        n_cmp++; if (RSP_VALID !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", RSP_VALID); end
        n_cmp++; if (OP_COUNT !== 8'd0) begin n_err++; $display("FAIL rmid_count: got %0d want 0", OP_COUNT); end
        RST_N = 1'b1;
        m_count = 0; m_last = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(posedge CLK); @(negedge CLK);
            if (RSP_VALID !== 1'b0 || OP_COUNT !== 8'd0) bad = 1'b1;
        end
        n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL rmid_no_response: got stray response/count, want none"); end
    endtask

    task automatic test_random;
        logic v0, v1, g, sub;
        logic [3:0] a, b, er;
        logic ec, eo;
        int d;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            v0 = 1'($urandom); v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            VALID0 = v0; A0 = 4'($urandom); B0 = 4'($urandom); SUB0 = 1'($urandom);
            VALID1 = v1; A1 = 4'($urandom); B1 = 4'($urandom); SUB1 = 1'($urandom);
            RSP_READY = 1'b0;
            g = (v0 && v1) ? !m_last : v1;
            a = g ? A1 : A0; b = g ? B1 : B0; sub = g ? SUB1 : SUB0;
            ref_op(a, b, sub, er, ec, eo);
            #1;
            n_cmp++; if ({READY0, READY1} !== {!g, g}) begin n_err++; $display("FAIL rnd_grant[%0d]: got %b want %b", i, {READY0, READY1}, {!g, g}); end
            @(posedge CLK); @(negedge CLK);
            VALID0 = 1'b0; VALID1 = 1'b0; A0 = 4'($urandom); A1 = 4'($urandom);
            @(posedge CLK); @(negedge CLK);
            n_cmp++; if ({RSP_VALID, RSP_ID, RSP_RESULT, RSP_COUT, RSP_OVF} !== {1'b1, g, er, ec, eo})
                begin n_err++; $display("FAIL rnd_rsp[%0d]: got v=%b id=%b r=%h c=%b o=%b want v=1 id=%b r=%h c=%b o=%b", i, RSP_VALID, RSP_ID, RSP_RESULT, RSP_COUT, RSP_OVF, g, er, ec, eo); end
            d = $urandom_range(0, 3);
            repeat (d) @(posedge CLK);
            @(negedge CLK);
            RSP_READY = 1'b1;
            @(posedge CLK); @(negedge CLK);
            RSP_READY = 1'b0;
            m_count = (m_count + 1) % 256; m_last = g;
            n_cmp++; if ({RSP_VALID, OP_COUNT} !== {1'b0, 8'(m_count)}) begin n_err++; $display("FAIL rnd_done[%0d]: got v=%b cnt=%0d want v=0 cnt=%0d", i, RSP_VALID, OP_COUNT, m_count); end
        end
    endtask

    task automatic test_wrap;
        @(negedge CLK); RST_N = 1'b0;
        @(negedge CLK); RST_N = 1'b1;
        m_count = 0; m_last = 1'b1;
        VALID1 = 1'b0; VALID0 = 1'b1; A0 = 4'd1; B0 = 4'd1; SUB0 = 1'b0; RSP_READY = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(posedge CLK); @(posedge CLK); @(negedge CLK);
            n_cmp++; if ({RSP_VALID, RSP_RESULT} !== {1'b1, 4'd2}) begin n_err++; $display("FAIL wrap_result[%0d]: got v=%b r=%h want v=1 r=2", i, RSP_VALID, RSP_RESULT); end
            @(posedge CLK); @(negedge CLK);
            m_count = (m_count + 1) % 256;
            n_cmp++; if (OP_COUNT !== 8'(m_count)) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d want %0d", i, OP_COUNT, m_count); end
        end
        VALID0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_sub();
        test_tie_ovf();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one add/subtract unit (operand-select/invert mux plus adder) between two requesters, using valid/ready handshakes.
- Arbitrates round-robin, sequences each operation through a 3-state FSM and returns a registered result with carry and signed-overflow flags on a response handshake.
- Sits between the two operand sources (switch/sequencer logic) and the shared ALU result path on the board datapath.

Parameters:
- WIDTH, 3, MSB index of operands; operand/result width is WIDTH+1 bits.

Ports:
- CLK  input  1  system clock, all state on rising edge
- RST_N  input  1  synchronous reset, active-low
- VALID0  input  1  requester 0 has an operation pending
- READY0  output  1  requester 0 granted; handshake when VALID0 && READY0
- A0  input  WIDTH+1  requester 0 operand A
- B0  input  WIDTH+1  requester 0 operand B
- SUB0  input  1  requester 0: 1 = A-B, 0 = A+B
- VALID1  input  1  requester 1 has an operation pending
- READY1  output  1  requester 1 granted
- A1  input  WIDTH+1  requester 1 operand A
- B1  input  WIDTH+1  requester 1 operand B
- SUB1  input  1  requester 1 operation select
- RSP_VALID  output  1  result valid
- RSP_READY  input  1  consumer accepts result
- RSP_ID  output  1  requester that issued the result
- RSP_RESULT  output  WIDTH+1  sum/difference, modulo 2^(WIDTH+1)
- RSP_COUT  output  1  adder carry-out (for SUB: 1 = no borrow)
- RSP_OVF  output  1  two's-complement overflow
- OP_COUNT  output  8  completed-operation counter

Behaviour:
- Reset (RST_N low at a rising edge):
  - state=IDLE, LAST=1 so requester 0 wins the first tie.
  - RSP_VALID, RSP_ID, RSP_RESULT, RSP_COUT, RSP_OVF and OP_COUNT all 0; READY0/READY1 = 0.
  - Reset mid-operation discards the captured operation and any pending response.
- FSM states:
  - IDLE:
    - READYx is combinational and only asserts in IDLE.
    - Only one VALID high: that requester is granted.
    - Both high: grant the requester != LAST.
    - None high: stay in IDLE.
    - On handshake: capture A, B, SUB and ID into internal registers; go to EXEC.
  - EXEC (exactly 1 cycle):
    - BSEL = SUB ? ~B : B.
    - {COUT, R} = A + BSEL + SUB, computed at WIDTH+2 bits.
    - OVF = (A[WIDTH] == BSEL[WIDTH]) && (R[WIDTH] != A[WIDTH]).
    - Register R, COUT, OVF and ID onto the RSP_* outputs; set RSP_VALID=1 and LAST=ID; go to RESP.
  - RESP:
    - RSP_VALID and all RSP_* outputs held stable until RSP_READY is high at an edge.
    - On that edge: RSP_VALID=0, OP_COUNT++, go to IDLE.
    - READY0/READY1 stay low throughout, even while VALIDs are held.
- Latency and throughput:
  - Handshake at edge N; RSP_VALID high from edge N+1 (registered at the end of the EXEC cycle).
  - Minimum 3 cycles per operation (IDLE, EXEC, RESP).
- After a response handshake, RSP_RESULT, RSP_COUT, RSP_OVF and RSP_ID hold their last values; only RSP_VALID drops.
- OP_COUNT wraps 255 -> 0 silently.
- Operands are sampled only at the handshake edge. Input changes after the handshake, or VALID dropping before a grant, have no effect.
- A requester whose VALID stays high after service is re-granted only if the other VALID is low.

Test Plan:
- Reset check: hold RST_N=0 for 2 edges with all VALIDs high -> READY0=READY1=0; RSP_VALID, RSP_RESULT and OP_COUNT all 0.
- Single subtract: VALID0=1, A0=5, B0=3, SUB0=1, RSP_READY=1 -> RSP_VALID high 1 edge after handshake; RESULT=2, COUT=1, OVF=0, ID=0; OP_COUNT=1 after the response handshake.
- Tie plus overflow:
  - Stimulus: right after reset, VALID0 and VALID1 both high; A0=0, B0=1, SUB0=1; A1=7, B1=1, SUB1=0.
  - First response: ID=0, RESULT=4'hF, COUT=0, OVF=0.
  - Second response: ID=1, RESULT=4'h8, COUT=0, OVF=1.
  - Third grant with both still valid goes to requester 0.
- Backpressure: RSP_READY=0 for 5 cycles after RSP_VALID rises -> RSP_* outputs constant, READY0/READY1 low, OP_COUNT unchanged; raising RSP_READY completes the response and the FSM returns to IDLE.
- Reset mid-operation: drive RST_N=0 during EXEC -> next cycle state=IDLE, RSP_VALID=0, OP_COUNT=0, no response issued.
- Counter wrap: 256 back-to-back single-requester adds (A0=1, B0=1) -> every RESULT=2; OP_COUNT reads 255 then wraps to 0.
